// File: rtl/axi_stream_if.sv
// ----------------------------------------------------------------------------
// axi_stream_if
// Minimal AXI4-Stream bundle used between the packet parsers.
//   tdata  [DATA_WIDTH-1:0]  beat payload
//   tvalid                   source has a beat
//   tready                   sink accepts the beat
//   tlast                    final beat of the packet
// master: drives tdata/tvalid/tlast, samples tready.
// slave : samples tdata/tvalid/tlast, drives tready.
// ----------------------------------------------------------------------------
interface axi_stream_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/tcp_rx_parser.sv
// ----------------------------------------------------------------------------
// tcp_rx_parser
// Parses one TCP segment per input packet: captures the fixed header, skips
// (but checksums) options, forwards the payload with zero latency and then
// presents a metadata record behind a valid/ready handshake.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   s_axis (slave)     segment bytes, header first, tlast on last byte
//   m_axis (master)    payload bytes only
//   csum_seed          pseudo-header partial sum, taken with header byte 0
//   meta_valid/ready   record handshake; record held until accepted
//   meta_*             header fields, payload length, checksum result, error
// ----------------------------------------------------------------------------
module tcp_rx_parser #(
   parameter int DATA_WIDTH = 8,
   parameter bit CSUM_EN    = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   axi_stream_if.slave  s_axis,
   axi_stream_if.master m_axis,
   input  logic [15:0]  csum_seed,
   output logic         meta_valid,
   input  logic         meta_ready,
   output logic [15:0]  meta_src_port,
   output logic [15:0]  meta_dst_port,
   output logic [31:0]  meta_seq_num,
   output logic [31:0]  meta_ack_num,
   output logic [3:0]   meta_data_offset,
   output logic [7:0]   meta_flags,
   output logic [15:0]  meta_window_size,
   output logic [15:0]  meta_payload_len,
   output logic         meta_csum_ok,
   output logic         meta_err
);

   typedef enum logic [2:0] {
      ST_HDR,
      ST_OPT,
      ST_PAYLOAD,
      ST_DRAIN,
      ST_META
   } state_e;

   state_e state_q, state_d;

   logic [5:0]  idx_q, idx_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [31:0] seq_q, seq_d;
   logic [31:0] ack_q, ack_d;
   logic [3:0]  off_q, off_d;
   logic [7:0]  flags_q, flags_d;
   logic [15:0] win_q, win_d;
   logic [15:0] plen_q, plen_d;
   logic        csum_ok_q, csum_ok_d;
   logic        err_q, err_d;

   // Checksum state: acc_q[16] is a pending end-around carry, hi_q holds the
   // high byte of a word until its low byte arrives, par_q = next byte is odd.
   logic [16:0] acc_q, acc_d;
   logic [7:0]  hi_q, hi_d;
   logic        par_q, par_d;

   logic [DATA_WIDTH-1:0] byte_w;
   logic        s_ready;
   logic        m_valid;
   logic        in_hs;
   logic        first_byte;
   logic [16:0] acc_base;
   logic        par_base;
   logic [16:0] acc_word;
   logic [15:0] fold_sum;
   logic [5:0]  opt_last;

   assign byte_w   = s_axis.tdata;
   assign opt_last = {off_q, 2'b00} - 6'd1;

   // One's-complement add; the carry left in bit 16 is folded in by the next
   // add, and the accumulator can never reach 17'h1FFFF, so one fold suffices.
   function automatic logic [16:0] csum_add(input logic [16:0] acc,
                                            input logic [15:0] word);
      return {1'b0, acc[15:0]} + {1'b0, word} + {16'd0, acc[16]};
   endfunction

   // NOTE: every signal written here gets a default first so no path through
   // the case/if tree leaves a value unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      src_d     = src_q;
      dst_d     = dst_q;
      seq_d     = seq_q;
      ack_d     = ack_q;
      off_d     = off_q;
      flags_d   = flags_q;
      win_d     = win_q;
      plen_d    = plen_q;
      csum_ok_d = csum_ok_q;
      err_d     = err_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      par_d     = par_q;
      s_ready   = 1'b0;
      m_valid   = 1'b0;

      // The seed replaces the stale accumulator on the first header byte.
      first_byte = (state_q == ST_HDR) && (idx_q == 6'd0);
      acc_base   = first_byte ? {1'b0, csum_seed} : acc_q;
      par_base   = first_byte ? 1'b0 : par_q;
      // Odd byte completes {hi, byte}; an even byte is the padded final word
      // if it turns out to be the last one.
      acc_word   = par_base ? csum_add(acc_base, {hi_q, byte_w})
                            : csum_add(acc_base, {byte_w, 8'h00});
      fold_sum   = acc_word[15:0] + {15'd0, acc_word[16]};

      case (state_q)
         ST_HDR, ST_OPT, ST_DRAIN: s_ready = 1'b1;
         ST_PAYLOAD: begin
            s_ready = m_axis.tready;
            m_valid = s_axis.tvalid;
         end
         default: s_ready = 1'b0;
      endcase

      in_hs = s_axis.tvalid && s_ready;

      case (state_q)
         ST_HDR: begin
            if (in_hs) begin
               idx_d = idx_q + 6'd1;
               case (idx_q)
                  6'd0: begin
                     // Start of a segment: clear the previous record.
                     src_d     = {byte_w, 8'h00};
                     dst_d     = 16'd0;
                     seq_d     = 32'd0;
                     ack_d     = 32'd0;
                     off_d     = 4'd0;
                     flags_d   = 8'd0;
                     win_d     = 16'd0;
                     plen_d    = 16'd0;
                     csum_ok_d = 1'b0;
                     err_d     = 1'b0;
                  end
                  6'd1:  src_d[7:0]    = byte_w;
                  6'd2:  dst_d[15:8]   = byte_w;
                  6'd3:  dst_d[7:0]    = byte_w;
                  6'd4:  seq_d[31:24]  = byte_w;
                  6'd5:  seq_d[23:16]  = byte_w;
                  6'd6:  seq_d[15:8]   = byte_w;
                  6'd7:  seq_d[7:0]    = byte_w;
                  6'd8:  ack_d[31:24]  = byte_w;
                  6'd9:  ack_d[23:16]  = byte_w;
                  6'd10: ack_d[15:8]   = byte_w;
                  6'd11: ack_d[7:0]    = byte_w;
                  6'd12: begin
                     off_d = byte_w[7:4];
                     if (byte_w[7:4] < 4'd5) err_d = 1'b1;
                  end
                  6'd13: flags_d       = byte_w;
                  6'd14: win_d[15:8]   = byte_w;
                  6'd15: win_d[7:0]    = byte_w;
                  default: ;
               endcase

               if (s_axis.tlast) begin
                  // Only a complete 20-byte header with no options may end here.
                  state_d = ST_META;
                  if ((idx_q != 6'd19) || (off_q != 4'd5)) err_d = 1'b1;
               end else if (idx_q == 6'd19) begin
                  if (err_q)               state_d = ST_DRAIN;
                  else if (off_q > 4'd5)   state_d = ST_OPT;
                  else                     state_d = ST_PAYLOAD;
               end
            end
         end

         ST_OPT: begin
            if (in_hs) begin
               idx_d = idx_q + 6'd1;
               if (idx_q == opt_last) begin
                  state_d = s_axis.tlast ? ST_META : ST_PAYLOAD;
               end else if (s_axis.tlast) begin
                  err_d   = 1'b1;
                  state_d = ST_META;
               end
            end
         end

         ST_PAYLOAD: begin
            if (in_hs) begin
               if (plen_q != 16'hFFFF) plen_d = plen_q + 16'd1;
               if (s_axis.tlast) state_d = ST_META;
            end
         end

         ST_DRAIN: begin
            if (in_hs && s_axis.tlast) state_d = ST_META;
         end

         ST_META: begin
            idx_d = 6'd0;
            if (meta_ready) state_d = ST_HDR;
         end

         default: state_d = ST_HDR;
      endcase

      // Checksum runs over every accepted byte of the segment.
      if (in_hs) begin
         par_d = ~par_base;
         if (par_base) begin
            acc_d = acc_word;
         end else begin
            acc_d = acc_base;
            hi_d  = byte_w;
         end
         if (s_axis.tlast) csum_ok_d = CSUM_EN ? (fold_sum == 16'hFFFF) : 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values of the others; the whole datapath is reset because the
   // record is visible on the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_HDR;
         idx_q     <= 6'd0;
         src_q     <= 16'd0;
         dst_q     <= 16'd0;
         seq_q     <= 32'd0;
         ack_q     <= 32'd0;
         off_q     <= 4'd0;
         flags_q   <= 8'd0;
         win_q     <= 16'd0;
         plen_q    <= 16'd0;
         csum_ok_q <= 1'b0;
         err_q     <= 1'b0;
         acc_q     <= 17'd0;
         hi_q      <= 8'd0;
         par_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         seq_q     <= seq_d;
         ack_q     <= ack_d;
         off_q     <= off_d;
         flags_q   <= flags_d;
         win_q     <= win_d;
         plen_q    <= plen_d;
         csum_ok_q <= csum_ok_d;
         err_q     <= err_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         par_q     <= par_d;
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = m_valid;
   assign m_axis.tdata  = s_axis.tdata;
   assign m_axis.tlast  = s_axis.tlast;

   assign meta_valid       = (state_q == ST_META);
   assign meta_src_port    = src_q;
   assign meta_dst_port    = dst_q;
   assign meta_seq_num     = seq_q;
   assign meta_ack_num     = ack_q;
   assign meta_data_offset = off_q;
   assign meta_flags       = flags_q;
   assign meta_window_size = win_q;
   assign meta_payload_len = plen_q;
   assign meta_csum_ok     = csum_ok_q;
   assign meta_err         = err_q;

endmodule

// File: tb/tb_tcp_rx_parser.sv
// ----------------------------------------------------------------------------
// tb_tcp_rx_parser
// Directed bench for tcp_rx_parser. Segments are assembled by the bench with a
// checksum computed over seed + segment, driven byte by byte, and the payload
// beats and metadata record are compared with hand-derived values.
// ----------------------------------------------------------------------------
module tb_tcp_rx_parser;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] csum_seed;
   logic        meta_valid;
   logic        meta_ready;
   logic [15:0] meta_src_port;
   logic [15:0] meta_dst_port;
   logic [31:0] meta_seq_num;
   logic [31:0] meta_ack_num;
   logic [3:0]  meta_data_offset;
   logic [7:0]  meta_flags;
   logic [15:0] meta_window_size;
   logic [15:0] meta_payload_len;
   logic        meta_csum_ok;
   logic        meta_err;

   axi_stream_if #(.DATA_WIDTH(8)) s_if ();
   axi_stream_if #(.DATA_WIDTH(8)) m_if ();

   tcp_rx_parser #(.DATA_WIDTH(8), .CSUM_EN(1'b1)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_axis           (s_if.slave),
      .m_axis           (m_if.master),
      .csum_seed        (csum_seed),
      .meta_valid       (meta_valid),
      .meta_ready       (meta_ready),
      .meta_src_port    (meta_src_port),
      .meta_dst_port    (meta_dst_port),
      .meta_seq_num     (meta_seq_num),
      .meta_ack_num     (meta_ack_num),
      .meta_data_offset (meta_data_offset),
      .meta_flags       (meta_flags),
      .meta_window_size (meta_window_size),
      .meta_payload_len (meta_payload_len),
      .meta_csum_ok     (meta_csum_ok),
      .meta_err         (meta_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] beats [$];   // {tlast, tdata} of every m_axis handshake
   logic [7:0] seg   [$];   // segment being driven
   logic [7:0] pay   [$];   // payload expected on m_axis

   always @(posedge clk) begin
      if (m_if.tvalid && m_if.tready) beats.push_back({m_if.tlast, m_if.tdata});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Fixed header fields, byte 12 given, nopt option bytes, then pay[].
   task automatic build(input logic [7:0] b12, input int nopt, input logic [15:0] seed);
      logic [7:0]  hdr [20] = '{8'h12, 8'h34, 8'h00, 8'h50, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                                8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h18, 8'hFF, 8'hFF,
                                8'h00, 8'h00, 8'h00, 8'h00};
      logic [31:0] sum;
      logic [15:0] c;
      seg.delete();
      hdr[12] = b12;
      foreach (hdr[i]) seg.push_back(hdr[i]);
      for (int i = 0; i < nopt; i++) seg.push_back(8'hA0 + 8'(i));
      foreach (pay[i]) seg.push_back(pay[i]);
      sum = {16'd0, seed};
      for (int i = 0; i < seg.size(); i += 2)
         sum += {16'd0, seg[i], (i + 1 < seg.size()) ? seg[i + 1] : 8'h00};
      while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
      c = ~sum[15:0];
      seg[16] = c[15:8];
      seg[17] = c[7:0];
   endtask

   // Drives seg[0 .. stop_at-1]; returns just before the edge that takes the
   // last of those bytes.
   task automatic drive(input int stop_at, input bit gaps, input bit rnd_mready);
      int i   = 0;
      int cyc = 0;
      int n   = seg.size();
      int lim = (stop_at < n) ? stop_at : n;
      while (i < lim && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         m_if.tready = rnd_mready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_if.tvalid = 1'b0;
         end else begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = seg[i];
            s_if.tlast  = (i == n - 1);
         end
         #1;
         if (s_if.tvalid && s_if.tready) i++;
      end
      check("drive_budget", i, lim);
   endtask

   // meta_valid must be up at the first negedge after the tlast handshake.
   task automatic wait_meta(input string tag);
      int cyc = 0;
      @(negedge clk);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      while (!meta_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_meta_latency"}, cyc, 0);
   endtask

   task automatic ack_meta(input string tag);
      meta_ready = 1'b1;
      @(negedge clk);
      meta_ready = 1'b0;
      check({tag, "_meta_dropped"}, meta_valid, 1'b0);
   endtask

   task automatic check_meta(input string tag, input logic [3:0] off, input logic [15:0] plen,
                             input logic err);
      check({tag, "_src"},   meta_src_port,    16'h1234);
      check({tag, "_dst"},   meta_dst_port,    16'h0050);
      check({tag, "_seq"},   meta_seq_num,     32'hDEADBEEF);
      check({tag, "_ack"},   meta_ack_num,     32'h01020304);
      check({tag, "_flags"}, meta_flags,       8'h18);
      check({tag, "_win"},   meta_window_size, 16'hFFFF);
      check({tag, "_off"},   meta_data_offset, off);
      check({tag, "_plen"},  meta_payload_len, plen);
      check({tag, "_err"},   meta_err,         err);
   endtask

   task automatic check_beats(input string tag, input int exp_n);
      check({tag, "_nbeats"}, beats.size(), exp_n);
      foreach (beats[i]) begin
         if (i < exp_n) begin
            check({tag, "_data"}, beats[i][7:0], pay[i]);
            check({tag, "_tlast"}, beats[i][8], (i == exp_n - 1));
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      csum_seed   = 16'h0000;
      meta_ready  = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 8'h00;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_meta_valid", meta_valid,       1'b0);
      check("rst_m_tvalid",   m_if.tvalid,      1'b0);
      check("rst_s_tready",   s_if.tready,      1'b1);
      check("rst_plen",       meta_payload_len, 16'h0000);
      check("rst_src",        meta_src_port,    16'h0000);
      check("rst_csum",       meta_csum_ok,     1'b0);
      rst_n = 1'b1;

      // Basic 20-byte header, 8-byte payload
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      build(8'h50, 0, 16'h0000);
      beats.delete();
      drive(1000, 1'b0, 1'b0);
      wait_meta("basic");
      check_meta("basic", 4'd5, 16'd8, 1'b0);
      check("basic_csum", meta_csum_ok, 1'b1);
      check_beats("basic", 8);
      ack_meta("basic");

      // 12 option bytes, odd 5-byte payload (padded final word)
      pay = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      build(8'h80, 12, 16'h0000);
      beats.delete();
      drive(1000, 1'b0, 1'b0);
      wait_meta("opts");
      check_meta("opts", 4'd8, 16'd5, 1'b0);
      check("opts_csum", meta_csum_ok, 1'b1);
      check_beats("opts", 5);
      ack_meta("opts");

      // Corrupted payload byte: forwarded as-is, checksum fails
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      build(8'h50, 0, 16'h0000);
      seg[22] = seg[22] ^ 8'h01;
      pay[2]  = pay[2] ^ 8'h01;
      beats.delete();
      drive(1000, 1'b0, 1'b0);
      wait_meta("corrupt");
      check("corrupt_csum", meta_csum_ok, 1'b0);
      check_beats("corrupt", 8);
      ack_meta("corrupt");

      // Nonzero seed folded into the generated checksum
      csum_seed = 16'hABCD;
      build(8'h50, 0, 16'hABCD);
      beats.delete();
      drive(1000, 1'b0, 1'b0);
      wait_meta("seed");
      check("seed_csum", meta_csum_ok, 1'b1);
      check("seed_plen", meta_payload_len, 16'd8);
      ack_meta("seed");
      csum_seed = 16'h0000;

      // Data offset 3: error, 10 trailing bytes drained, nothing forwarded
      pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
      build(8'h30, 0, 16'h0000);
      beats.delete();
      drive(1000, 1'b0, 1'b0);
      wait_meta("badoff");
      check_meta("badoff", 4'd3, 16'd0, 1'b1);
      check_beats("badoff", 0);
      ack_meta("badoff");

      // tlast on header byte 15
      pay.delete();
      build(8'h50, 0, 16'h0000);
      while (seg.size() > 16) void'(seg.pop_back());
      beats.delete();
      drive(1000, 1'b0, 1'b0);
      wait_meta("trunc");
      check_meta("trunc", 4'd5, 16'd0, 1'b1);
      check_beats("trunc", 0);
      ack_meta("trunc");

      // Header-only segment, meta_ready already high (1-cycle record)
      build(8'h50, 0, 16'h0000);
      beats.delete();
      meta_ready = 1'b1;
      drive(1000, 1'b0, 1'b0);
      wait_meta("hdronly");
      check_meta("hdronly", 4'd5, 16'd0, 1'b0);
      check("hdronly_csum", meta_csum_ok, 1'b1);
      check_beats("hdronly", 0);
      ack_meta("hdronly");

      // Random gaps/backpressure, then META held 20 cycles against a waiting byte
      pay = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
      build(8'h60, 4, 16'h0000);
      beats.delete();
      drive(1000, 1'b1, 1'b1);
      wait_meta("stall");
      check_beats("stall", 6);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h12;
      s_if.tlast  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("stall_s_tready", s_if.tready,      1'b0);
         check("stall_valid",    meta_valid,       1'b1);
         check("stall_plen",     meta_payload_len, 16'd6);
         check("stall_seq",      meta_seq_num,     32'hDEADBEEF);
      end
      check_meta("stall", 4'd6, 16'd6, 1'b0);
      check("stall_csum", meta_csum_ok, 1'b1);
      s_if.tvalid = 1'b0;
      ack_meta("stall");

      pay = '{8'hE0, 8'hE1, 8'hE2};
      build(8'h50, 0, 16'h0000);
      beats.delete();
      drive(1000, 1'b1, 1'b1);
      wait_meta("after");
      check_meta("after", 4'd5, 16'd3, 1'b0);
      check("after_csum", meta_csum_ok, 1'b1);
      check_beats("after", 3);
      ack_meta("after");

      // Reset in the middle of the payload
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      build(8'h50, 0, 16'h0000);
      drive(24, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_meta_valid", meta_valid,       1'b0);
      check("abort_m_tvalid",   m_if.tvalid,      1'b0);
      check("abort_s_tready",   s_if.tready,      1'b1);
      check("abort_plen",       meta_payload_len, 16'h0000);
      check("abort_src",        meta_src_port,    16'h0000);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      beats.delete();
      drive(1000, 1'b0, 1'b0);
      wait_meta("post_rst");
      check_meta("post_rst", 4'd5, 16'd8, 1'b0);
      check("post_rst_csum", meta_csum_ok, 1'b1);
      check_beats("post_rst", 8);
      ack_meta("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tcp_rx_parser.md
# tcp_rx_parser

Parametrised successor TCP receive parser: consumes a byte-wide AXI4-Stream carrying one TCP segment per packet (TCP header first, tlast on the final byte) and forwards only the payload on a master AXI4-Stream. It accepts TCP options (data offset 5..15), verifies the one's-complement checksum against a caller-supplied pseudo-header seed, and detects malformed or truncated segments. It presents one metadata record per segment behind a valid/ready handshake and sits between the IPv4 parser and the connection logic.

## Interface
- DATA_WIDTH, 8: stream width in bits; only 8 supported.
- CSUM_EN, 1: 1 = compute and check checksum; 0 = meta_csum_ok forced 1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis  slave axi_stream_if  DATA_WIDTH  segment bytes (tdata/tvalid/tready/tlast).
- m_axis  master axi_stream_if  DATA_WIDTH  payload bytes.
- csum_seed  in  16  pseudo-header partial sum (src/dst IP, proto, TCP length), sampled on first header byte.
- meta_valid  out  1  metadata record available.
- meta_ready  in  1  consumer accepts the record.
- meta_src_port, meta_dst_port  out  16  header bytes 0-1, 2-3.
- meta_seq_num, meta_ack_num  out  32  header bytes 4-7, 8-11.
- meta_data_offset  out  4  byte 12 [7:4].
- meta_flags  out  8  byte 13.
- meta_window_size  out  16  bytes 14-15.
- meta_payload_len  out  16  payload bytes forwarded; saturates at 16'hFFFF.
- meta_csum_ok  out  1  folded sum == 16'hFFFF.
- meta_err  out  1  data offset < 5 or tlast before end of header+options.

## Operation
- States: HDR (bytes 0-19), OPT (bytes 20..4*offset-1), PAYLOAD, DRAIN, META.
- Multi-byte fields are big-endian and captured as bytes arrive. A byte index counter (6 bits) counts header/option bytes.
- HDR: s_axis.tready = 1. At byte 12, offset < 5 sets err.
  - After byte 19: go to DRAIN if err; OPT if offset > 5; PAYLOAD otherwise.
  - tlast on byte 19 with no err and offset = 5: go to META with payload_len 0.
  - tlast earlier than byte 19 sets err and goes to META.
- OPT: s_axis.tready = 1. Option bytes are discarded but summed.
  - After byte 4*offset-1: go to PAYLOAD, or to META if that byte carries tlast.
  - tlast earlier sets err and goes to META.
- PAYLOAD: combinational pass-through.
  - m_axis.tdata/tvalid/tlast = s_axis values; s_axis.tready = m_axis.tready.
  - Each handshake increments payload_len.
  - The tlast handshake goes to META.
- DRAIN: s_axis.tready = 1. Nothing is forwarded. Exits to META on tlast.
- META: s_axis.tready = 0 and meta_valid = 1. All meta_* outputs are held stable until meta_valid && meta_ready, then go to HDR.
- Checksum:
  - 17-bit accumulator is loaded with csum_seed at byte 0.
  - Even-index bytes form the high byte of a 16-bit word; the following odd byte forms the low byte.
  - Each word is added with end-around carry.
  - An odd final byte is padded with 8'h00.
  - Checksum field bytes 16-17 are summed as received.
  - csum_ok = (folded sum == 16'hFFFF) evaluated at tlast.
- m_axis.tvalid = 0 in every state except PAYLOAD.

## Timing
- Reset: state HDR; all meta_* = 0; meta_valid = 0; m_axis.tvalid = 0; s_axis.tready = 1 (HDR).
- Payload latency is 0 cycles (combinational). Backpressure on m_axis propagates to s_axis in the same cycle.
- meta_valid rises in the cycle after the tlast handshake. Minimum record hold is 1 cycle; meta_ready may already be high.
- A new segment's first byte can be accepted in the cycle after the meta handshake. There is no overlap, so the upstream stalls while META waits.
- meta_ready asserted outside META has no effect.
- tvalid low cycles in any state do not advance the counter or accumulator.
- rst_n asserted mid-packet aborts at once:
  - outputs return to reset values;
  - the remainder of the aborted segment is parsed as a new segment by design. The upstream is reset together with this block.

## Test plan
- 20-byte header (src 0x1234, dst 0x0050, seq 0xDEADBEEF, ack 0x01020304, flags 0x18, win 0xFFFF), 8-byte payload, correct checksum, seed 0 -> m_axis carries exactly the 8 bytes, tlast on the 8th; meta fields match; payload_len 8; csum_ok 1; err 0.
- Same segment with byte 12 = 0x80, 12 option bytes, 5-byte payload -> options not forwarded; data_offset 8; payload_len 5; csum_ok 1 (odd-length padding).
- Corrupt one payload byte -> payload forwarded unchanged; csum_ok 0. Nonzero csum_seed with checksum generated over the seed -> csum_ok 1.
- Byte 12 = 0x30 with 10 trailing bytes -> nothing on m_axis; err 1; input drained to tlast; meta_valid follows.
- tlast on header byte 15 -> err 1; payload_len 0. Header-only segment (tlast on byte 19) -> err 0; payload_len 0; no m_axis beat.
- Random m_axis.tready and s_axis.tvalid gaps; meta_ready held low 20 cycles -> s_axis.tready 0 throughout META; meta stable; next segment parsed correctly after the handshake. Also apply reset mid-payload -> all outputs reset next cycle.
